// File: rtl/ddr_test_sequencer.sv
// ddr_test_sequencer
// Top-level sequencer for the DDR3 AXI traffic test. Runs the init pass,
// then issues write/read burst pairs sharing one LFSR-derived address, ID
// and length per pair. A per-phase watchdog and a sticky data-error flag
// are folded into the final pass/fail status.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   test_start                  level: high = run, low = stop
//   cfg_burst_num/_pattern_01/_random_data   run config, sampled leaving IDLE
//   init_done, write_done_p, read_done_p, rd_idle, err_flag   controller status
//   init_start, write_en, read_en              controller requests
//   random_rw_addr/_axi_id/_axi_len            per-pair burst fields
//   data_pattern_01, random_data_en            latched data config
//   burst_cnt, err_sticky, timeout_err, busy, test_done   status
//
// state | meaning
// IDLE  | waiting for test_start
// INIT  | full-memory init pass running
// GEN   | advance LFSR, latch pair fields
// WR    | write burst requested, waiting for address accept
// RD    | read burst requested, waiting for address accept
// DRAIN | waiting for read checker to go idle (min 2 cycles)
// NEXT  | count the pair, decide continue or stop
// DONE  | run finished, status held until test_start drops
module ddr_test_sequencer #(
  parameter int unsigned CTRL_ADDR_WIDTH = 28,
  parameter int unsigned MEM_SPACE_AW    = 18,
  parameter logic [31:0] LFSR_SEED       = 32'h1ACE_B00C,
  parameter logic [19:0] TIMEOUT         = 20'hFFFFF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       test_start,
  input  logic [15:0]                cfg_burst_num,
  input  logic                       cfg_pattern_01,
  input  logic                       cfg_random_data,
  input  logic                       init_done,
  input  logic                       write_done_p,
  input  logic                       read_done_p,
  input  logic                       rd_idle,
  input  logic                       err_flag,
  output logic                       init_start,
  output logic                       write_en,
  output logic                       read_en,
  output logic [CTRL_ADDR_WIDTH-1:0] random_rw_addr,
  output logic [3:0]                 random_axi_id,
  output logic [3:0]                 random_axi_len,
  output logic                       data_pattern_01,
  output logic                       random_data_en,
  output logic [15:0]                burst_cnt,
  output logic                       err_sticky,
  output logic                       timeout_err,
  output logic                       busy,
  output logic                       test_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_GEN, S_WR, S_RD, S_DRAIN, S_NEXT, S_DONE
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  state_t                     state, state_nxt;
  logic [31:0]                lfsr, lfsr_nxt;
  logic [19:0]                wd_cnt, wd_cnt_nxt;
  logic [15:0]                burst_num, burst_num_nxt;
  logic [15:0]                burst_cnt_nxt, burst_inc;
  logic [CTRL_ADDR_WIDTH-1:0] addr_nxt;
  logic [3:0]                 id_nxt, len_nxt;
  logic                       pat_nxt, rnd_nxt;
  logic                       err_nxt, tmo_nxt;
  logic                       waiting, wd_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      lfsr            <= LFSR_SEED;
      wd_cnt          <= '0;
      burst_num       <= '0;
      burst_cnt       <= '0;
      random_rw_addr  <= '0;
      random_axi_id   <= '0;
      random_axi_len  <= '0;
      data_pattern_01 <= 1'b0;
      random_data_en  <= 1'b0;
      err_sticky      <= 1'b0;
      timeout_err     <= 1'b0;
      init_start      <= 1'b0;
      write_en        <= 1'b0;
      read_en         <= 1'b0;
      busy            <= 1'b0;
      test_done       <= 1'b0;
    end else begin
      state           <= state_nxt;
      lfsr            <= lfsr_nxt;
      wd_cnt          <= wd_cnt_nxt;
      burst_num       <= burst_num_nxt;
      burst_cnt       <= burst_cnt_nxt;
      random_rw_addr  <= addr_nxt;
      random_axi_id   <= id_nxt;
      random_axi_len  <= len_nxt;
      data_pattern_01 <= pat_nxt;
      random_data_en  <= rnd_nxt;
      err_sticky      <= err_nxt;
      timeout_err     <= tmo_nxt;
      // Enables and status are registered images of the next state.
      init_start      <= (state_nxt == S_INIT);
      write_en        <= (state_nxt == S_WR);
      read_en         <= (state_nxt == S_RD);
      busy            <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      test_done       <= (state_nxt == S_DONE);
    end
  end

  always_comb begin
    state_nxt     = state;
    lfsr_nxt      = lfsr;
    burst_num_nxt = burst_num;
    burst_cnt_nxt = burst_cnt;
    addr_nxt      = random_rw_addr;
    id_nxt        = random_axi_id;
    len_nxt       = random_axi_len;
    pat_nxt       = data_pattern_01;
    rnd_nxt       = random_data_en;
    err_nxt       = err_sticky;
    tmo_nxt       = timeout_err;
    burst_inc     = burst_cnt + 16'd1;

    waiting    = (state == S_INIT) || (state == S_WR) ||
                 (state == S_RD)   || (state == S_DRAIN);
    // wd_cnt holds cycles already spent in the phase, so the phase lasts
    // at most TIMEOUT cycles; expiry wins over a same-cycle done pulse.
    wd_expired = waiting && (wd_cnt == TIMEOUT - 20'd1);

    if ((state != S_IDLE) && err_flag) err_nxt = 1'b1;

    if (wd_expired) begin
      tmo_nxt   = 1'b1;
      state_nxt = S_DONE;
    end else begin
      case (state)
        S_IDLE: if (test_start) begin
          burst_num_nxt = cfg_burst_num;
          pat_nxt       = cfg_pattern_01;
          rnd_nxt       = cfg_random_data;
          burst_cnt_nxt = '0;
          err_nxt       = 1'b0;
          tmo_nxt       = 1'b0;
          state_nxt     = S_INIT;
        end
        S_INIT: if (init_done) state_nxt = S_GEN;
        S_GEN: begin
          lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'd0);
          len_nxt  = lfsr_nxt[3:0];
          id_nxt   = lfsr_nxt[7:4];
          // 64-unit alignment keeps a 16-beat burst inside one block.
          addr_nxt = '0;
          addr_nxt[MEM_SPACE_AW:6] = lfsr_nxt[8 +: MEM_SPACE_AW-5];
          state_nxt = S_WR;
        end
        S_WR: if (write_done_p) state_nxt = S_RD;
        S_RD: if (read_done_p) state_nxt = S_DRAIN;
        // wd_cnt != 0 means at least one DRAIN cycle already passed.
        S_DRAIN: if ((wd_cnt != '0) && rd_idle) state_nxt = S_NEXT;
        S_NEXT: begin
          burst_cnt_nxt = burst_inc;
          if (!test_start || ((burst_num != '0) && (burst_inc == burst_num)))
            state_nxt = S_DONE;
          else
            state_nxt = S_GEN;
        end
        S_DONE: if (!test_start) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end

    wd_cnt_nxt = (waiting && (state_nxt == state)) ? wd_cnt + 20'd1 : '0;
  end

endmodule

// File: tb/tb_ddr_test_sequencer.sv
// Testbench for ddr_test_sequencer: directed run scenarios with randomized
// response timing, checked against an LFSR/pair-count reference model.
module tb_ddr_test_sequencer;
  localparam int          CAW  = 28;
  localparam int          AW   = 18;
  localparam logic [19:0] TO   = 20'd100;
  localparam logic [31:0] SEED = 32'h1ACE_B00C;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           test_start = 1'b0;
  logic [15:0]    cfg_burst_num = '0;
  logic           cfg_pattern_01 = 1'b0;
  logic           cfg_random_data = 1'b0;
  logic           init_done = 1'b0;
  logic           write_done_p = 1'b0;
  logic           read_done_p = 1'b0;
  logic           rd_idle = 1'b1;
  logic           err_flag = 1'b0;
  logic           init_start, write_en, read_en;
  logic [CAW-1:0] random_rw_addr;
  logic [3:0]     random_axi_id, random_axi_len;
  logic           data_pattern_01, random_data_en;
  logic [15:0]    burst_cnt;
  logic           err_sticky, timeout_err, busy, test_done;

  ddr_test_sequencer #(
    .CTRL_ADDR_WIDTH(CAW), .MEM_SPACE_AW(AW), .LFSR_SEED(SEED), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .test_start(test_start),
    .cfg_burst_num(cfg_burst_num), .cfg_pattern_01(cfg_pattern_01),
    .cfg_random_data(cfg_random_data), .init_done(init_done),
    .write_done_p(write_done_p), .read_done_p(read_done_p), .rd_idle(rd_idle),
    .err_flag(err_flag), .init_start(init_start), .write_en(write_en),
    .read_en(read_en), .random_rw_addr(random_rw_addr),
    .random_axi_id(random_axi_id), .random_axi_len(random_axi_len),
    .data_pattern_01(data_pattern_01), .random_data_en(random_data_en),
    .burst_cnt(burst_cnt), .err_sticky(err_sticky), .timeout_err(timeout_err),
    .busy(busy), .test_done(test_done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_lfsr;
  int          exp_cnt;
  logic [31:0] e_addr;
  logic [3:0]  e_id, e_len;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] addr_of(input logic [31:0] v);
    logic [31:0] f;
    f = (v >> 8) & ((32'd1 << (AW - 5)) - 32'd1);
    return f << 6;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, {29'd0, init_start, write_en, read_en}, 32'd0);
    chk({tag, "_addr"}, 32'(random_rw_addr), 32'd0);
    chk({tag, "_idlen"}, {24'd0, random_axi_id, random_axi_len}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, burst_cnt}, 32'd0);
    chk({tag, "_status"}, {26'd0, data_pattern_01, random_data_en, err_sticky,
                           timeout_err, busy, test_done}, 32'd0);
  endtask

  task automatic start_run(input logic [15:0] bn, input logic p, input logic r,
                           input int init_delay);
    int hi;
    cfg_burst_num = bn; cfg_pattern_01 = p; cfg_random_data = r;
    init_done = 1'b0; rd_idle = 1'b1; test_start = 1'b1;
    tick;
    // Config changes after the start edge must have no effect.
    cfg_burst_num = 16'($urandom_range(1000, 60000));
    cfg_pattern_01 = ~p; cfg_random_data = ~r;
    chk("start_init_start", init_start, 1);
    chk("start_busy", busy, 1);
    chk("start_cnt_clr", burst_cnt, 0);
    chk("start_err_clr", err_sticky, 0);
    chk("start_tmo_clr", timeout_err, 0);
    chk("cfg_latch", {data_pattern_01, random_data_en}, {p, r});
    hi = 1;
    repeat (init_delay - 1) begin
      tick;
      hi += int'(init_start);
    end
    chk("init_hold", hi, init_delay);
    init_done = 1'b1;
    tick;
    chk("init_drop", init_start, 0);
    chk("gen_no_wr", write_en, 0);
    exp_cnt = 0;
  endtask

  task automatic wait_wr_fields;
    int n;
    n = 0;
    while (!write_en && n < 50) begin tick; n++; end
    chk("wr_seen", write_en, 1);
    m_lfsr = lfsr_step(m_lfsr);
    e_addr = addr_of(m_lfsr);
    e_id   = m_lfsr[7:4];
    e_len  = m_lfsr[3:0];
    chk("wr_addr", 32'(random_rw_addr), e_addr);
    chk("wr_id_len", {random_axi_id, random_axi_len}, {e_id, e_len});
    chk("addr_align", 32'(random_rw_addr[5:0]), 0);
    chk("addr_upper", 32'(random_rw_addr >> (AW + 1)), 0);
  endtask

  task automatic do_pair(input bit drop_rd, input bit err_drain, input bit last);
    int n;
    wait_wr_fields();
    repeat ($urandom_range(0, 3)) tick;
    write_done_p = 1'b1; tick; write_done_p = 1'b0;
    chk("rd_en_on", {write_en, read_en}, 2'b01);
    rd_idle = 1'b0;
    chk("rd_addr", 32'(random_rw_addr), e_addr);
    chk("rd_id_len", {random_axi_id, random_axi_len}, {e_id, e_len});
    if (drop_rd) test_start = 1'b0;
    repeat ($urandom_range(0, 3)) tick;
    read_done_p = 1'b1; tick; read_done_p = 1'b0;
    chk("drain_no_en", {write_en, read_en, busy}, 3'b001);
    if (err_drain) begin
      err_flag = 1'b1; tick; err_flag = 1'b0;
      chk("err_set", err_sticky, 1);
    end
    repeat ($urandom_range(0, 3)) tick;
    rd_idle = 1'b1;
    exp_cnt++;
    n = 0;
    while (burst_cnt != 16'(exp_cnt) && n < 50) begin tick; n++; end
    chk("burst_cnt", burst_cnt, exp_cnt);
    chk("done_flag", {test_done, busy}, last ? 2'b10 : 2'b01);
  endtask

  initial begin
    int n;
    bit any_wr;
    m_lfsr = SEED;
    tick; tick;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick;

    // Three pairs, prompt responses.
    start_run(16'd3, 1'b1, 1'b0, 10);
    do_pair(0, 0, 0);
    do_pair(0, 0, 0);
    do_pair(0, 0, 1);
    chk("run1_err", err_sticky, 0);
    any_wr = 0;
    repeat (5) begin tick; any_wr |= write_en; end
    chk("run1_hold_done", {test_done, any_wr}, 2'b10);
    test_start = 1'b0;
    tick;
    chk("run1_idle", {test_done, busy}, 2'b00);
    chk("run1_cnt_held", burst_cnt, 3);

    // Unbounded run stopped during RD of pair 5.
    start_run(16'd0, 1'b0, 1'b1, int'($urandom_range(1, 6)));
    repeat (4) do_pair(0, 0, 0);
    do_pair(1, 0, 1);
    any_wr = 0;
    repeat (20) begin tick; any_wr |= write_en; end
    chk("stop_no_wr", any_wr, 0);
    chk("stop_cnt", burst_cnt, 5);

    // Data error in DRAIN of pair 2.
    start_run(16'd3, 1'b1, 1'b1, int'($urandom_range(1, 6)));
    do_pair(0, 0, 0);
    do_pair(0, 1, 0);
    do_pair(0, 0, 1);
    chk("err_at_done", err_sticky, 1);
    test_start = 1'b0;
    tick;
    chk("err_held_idle", err_sticky, 1);

    // Watchdog: write_done_p withheld (start_run also checks err clear).
    start_run(16'd1, 1'b0, 1'b0, 3);
    wait_wr_fields();
    n = 0;
    while (write_en && n < 300) begin n++; tick; end
    chk("wd_cycles", (n >= int'(TO) && n <= int'(TO) + 1), 1);
    chk("wd_status", {timeout_err, test_done, write_en, busy}, 4'b1100);
    chk("wd_cnt_same", burst_cnt, 0);
    write_done_p = 1'b1; tick; write_done_p = 1'b0;
    chk("wd_late_pulse", {read_en, test_done}, 2'b01);
    test_start = 1'b0;
    tick;

    // Asynchronous reset during WR.
    start_run(16'd2, 1'b1, 1'b1, 4);
    wait_wr_fields();
    #3 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    test_start = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    m_lfsr = SEED;
    start_run(16'd1, 1'b0, 1'b1, 2);
    do_pair(0, 0, 1);
    test_start = 1'b0;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
